vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
Receive-side counterpart of the 640x480 VGA timing generator. It samples Hsync_n, Vsync_n and a 12-bit RGB pixel bus on the pixel clock, recovers the active-area coordinates, and re-emits valid pixels with their position. It also measures line and frame periods and reports lock and timing errors. It is used as an in-fabric monitor and checker and as the capture front end for frame-grab logic.

Parameters:
SCREEN_X, 640, active pixels per line
SCREEN_Y, 480, active lines per frame
H_BACK, 48, clocks from Hsync_n rising edge to first active pixel
V_BACK, 33, hcnt-line index (vcnt) of first active line
H_MIN, 795, minimum legal line period in clocks
H_MAX, 805, maximum legal line period in clocks; also the watchdog limit
V_MIN, 520, minimum legal lines per frame
V_MAX, 530, maximum legal lines per frame
LOCK_FRAMES, 2, consecutive good frames required to assert locked

Ports:
clk  in  1  pixel clock, 25 MHz
rst  in  1  synchronous reset, active low
Hsync_n  in  1  horizontal sync, active low
Vsync_n  in  1  vertical sync, active low
pixelIn  in  12  RGB pixel sample
pixelOut  out  12  recovered pixel; 0 when not valid
pixel_valid  out  1  pixelOut/posX/posY carry an active pixel
posX  out  10  active x coordinate; 0 when not valid
posY  out  9  active y coordinate; 0 when not valid
line_start  out  1  one-cycle pulse coincident with the x=0 pixel
frame_start  out  1  one-cycle pulse coincident with the x=0, y=0 pixel
locked  out  1  timing stable
h_err  out  1  one-cycle pulse on a bad line period or watchdog expiry
v_err  out  1  one-cycle pulse on a bad frame line count
line_len  out  11  last measured line period in clocks
frame_lines  out  10  last measured lines per frame

Behaviour:
- Reset (rst=0 at clk edge): all outputs are 0, all counters are 0, and the edge-history and "first edge seen" flags are cleared. Reset mid-frame discards all measurements; lock must be re-acquired from scratch.
- Stage 1 registers Hsync_n, Vsync_n and pixelIn (s1). Stage 2 holds the previous s1 sync values for edge detection.
  - Rise = s1 high and previous low.
  - All outputs are registered. A pixel on pixelIn at cycle t appears on pixelOut at t+2.
- hcnt (11 bit):
  - Set to 0 for the sample in which Hsync_n is first seen high.
  - Otherwise +1 per clock, saturating at 2047.
- vcnt (10 bit):
  - Set to 0 on a Vsync_n rise.
  - Otherwise +1 on each Hsync_n rise, saturating at 1023.
  - If a Vsync_n rise and an Hsync_n rise occur in the same cycle, vcnt is set to 0.
- Active region: H_BACK <= hcnt < H_BACK+SCREEN_X and V_BACK <= vcnt < V_BACK+SCREEN_Y.
  - In the active region: pixel_valid=1, posX=hcnt-H_BACK, posY=vcnt-V_BACK, pixelOut=sample.
  - Outside it: pixel_valid=0 and pixelOut/posX/posY are 0.
  - The active region is evaluated only after at least one Hsync_n rise and one Vsync_n rise since reset.
- line_start=1 with posX=0. frame_start=1 with posX=0 and posY=0.
- Line period: clocks between consecutive Hsync_n rises.
  - Latched into line_len at each rise, except the first rise after reset.
  - Period outside [H_MIN,H_MAX] gives h_err=1 for one cycle and locked=0.
- Watchdog: hcnt reaching H_MAX+1 without an Hsync_n rise gives h_err=1 once (no repeat until the next rise), locked=0, and the active region is suppressed until the next Hsync_n rise.
- Frame count: Hsync_n rises between consecutive Vsync_n rises.
  - Latched into frame_lines at each Vsync_n rise, except the first rise after reset.
  - Count outside [V_MIN,V_MAX] gives v_err=1 for one cycle and locked=0.
- Lock FSM, states UNLOCKED, ACQUIRE, LOCKED:
  - UNLOCKED -> ACQUIRE on the first Vsync_n rise.
  - In ACQUIRE, a good-frame counter increments at each Vsync_n rise closing a frame with no h_err or v_err.
  - ACQUIRE -> LOCKED when the counter reaches LOCK_FRAMES; locked=1 from the next cycle.
  - Any h_err or v_err in ACQUIRE or LOCKED goes to ACQUIRE with the counter cleared and locked=0 in the same cycle as the error pulse.
- Pixel output does not depend on locked.

Test Plan:
- Nominal timing: 800-clock lines with Hsync_n low at clocks 656..751, 525-line frames with Vsync_n low on lines 490..491, pixelIn={line[5:0],clk[5:0]} -> line 0 clock 0 emerges 2 cycles later with posX=0, posY=0, frame_start=1, pixelOut=12'h000. Line 10 clock 5 emerges with posX=5, posY=10, pixelOut=12'h285. 307200 valid pixels per frame, line_len=800, frame_lines=525.
- Lock acquisition after reset -> locked=0 through the 2nd Vsync_n rise, and locked=1 one cycle after the 3rd Vsync_n rise.
- One line stretched to 820 clocks while locked -> h_err pulse at that Hsync_n rise, line_len=820, locked=0; locked re-asserts after 2 further clean frames.
- Hsync_n held high for 900 clocks -> single h_err at hcnt=806, pixel_valid=0 until the next Hsync_n rise.
- Frame of 510 lines -> v_err pulse, frame_lines=510, locked=0.
- rst=0 for 1 cycle mid-frame at line 200 -> all outputs 0 next cycle; no pixel_valid until the first Vsync_n rise after reset, and the first valid pixel is x=0, y=0.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive-side decoder for 640x480-style VGA timing. It samples the sync
//   lines and the pixel bus on the pixel clock, recovers active-area
//   coordinates and re-emits valid pixels with their position two clocks
//   after they enter. It also measures the line period and the lines per
//   frame, flags out-of-range timing, and tracks lock.
//
// Ports
//   clk          pixel clock
//   rst          synchronous reset, active low
//   Hsync_n      horizontal sync, active low
//   Vsync_n      vertical sync, active low
//   pixelIn      12-bit RGB sample
//   pixelOut     recovered pixel, 0 when not valid
//   pixel_valid  pixelOut/posX/posY carry an active pixel
//   posX, posY   active coordinates, 0 when not valid
//   line_start   pulse with the x=0 pixel
//   frame_start  pulse with the x=0, y=0 pixel
//   locked       timing stable
//   h_err        pulse on a bad line period or watchdog expiry
//   v_err        pulse on a bad frame line count
//   line_len     last measured line period in clocks
//   frame_lines  last measured lines per frame
module vga_sync_decoder #(
  parameter int SCREEN_X    = 640,
  parameter int SCREEN_Y    = 480,
  parameter int H_BACK      = 48,
  parameter int V_BACK      = 33,
  parameter int H_MIN       = 795,
  parameter int H_MAX       = 805,
  parameter int V_MIN       = 520,
  parameter int V_MAX       = 530,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Hsync_n,
  input  logic        Vsync_n,
  input  logic [11:0] pixelIn,
  output logic [11:0] pixelOut,
  output logic        pixel_valid,
  output logic [9:0]  posX,
  output logic [8:0]  posY,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines
);

  localparam logic [10:0] X_LO      = 11'(H_BACK);
  localparam logic [10:0] X_HI      = 11'(H_BACK + SCREEN_X);
  localparam logic [9:0]  Y_LO      = 10'(V_BACK);
  localparam logic [9:0]  Y_HI      = 10'(V_BACK + SCREEN_Y);
  localparam logic [10:0] LEN_MIN   = 11'(H_MIN);
  localparam logic [10:0] LEN_MAX   = 11'(H_MAX);
  localparam logic [10:0] WD_LIMIT  = 11'(H_MAX + 1);
  localparam logic [9:0]  LINES_MIN = 10'(V_MIN);
  localparam logic [9:0]  LINES_MAX = 10'(V_MAX);
  localparam int          GW        = $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } lockState_t;

  function automatic logic [10:0] satInc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] satInc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  // Stage 1: input sample registers
  logic        hs_p1, vs_p1;
  logic [11:0] pix_p1;
  // Stage 2: previous sync levels for edge detection
  logic        hs_p2, vs_p2;

  // Timing state aligned with the stage-1 sample
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic        hSeen, vSeen, wdTrip;

  // Stage-2 output registers
  logic        vld_p2;
  logic [11:0] pix_p2;
  logic [9:0]  posX_p2;
  logic [8:0]  posY_p2;
  logic        lineStart_p2, frameStart_p2;

  lockState_t  state, stateNext;
  logic [GW-1:0] goodCnt, goodCntNext;
  logic        frameBad, frameBadNext;

  logic        hRise, vRise;
  logic [10:0] hcntNext, linePeriod;
  logic [9:0]  vcntNext;
  logic        lineBad, wdFire, hErrNow, vErrNow, wdBlock, activeNow;
  logic [9:0]  xNext;
  logic [8:0]  yNext;

  always_comb begin
    hRise      = hs_p1 & ~hs_p2;
    vRise      = vs_p1 & ~vs_p2;
    hcntNext   = hRise ? 11'd0 : satInc11(hcnt);
    vcntNext   = vRise ? 10'd0 : (hRise ? satInc10(vcnt) : vcnt);
    linePeriod = satInc11(hcnt);
    // The first rise after reset only anchors the counters; nothing to measure yet.
    lineBad    = hRise & hSeen & ((linePeriod < LEN_MIN) | (linePeriod > LEN_MAX));
    wdFire     = hSeen & ~hRise & ~wdTrip & (hcntNext == WD_LIMIT);
    hErrNow    = lineBad | wdFire;
    vErrNow    = vRise & vSeen & ((vcnt < LINES_MIN) | (vcnt > LINES_MAX));
    // A tripped watchdog blanks the picture until horizontal sync comes back.
    wdBlock    = (wdTrip & ~hRise) | wdFire;
    activeNow  = (hSeen | hRise) & (vSeen | vRise) & ~wdBlock &
                 (hcntNext >= X_LO) & (hcntNext < X_HI) &
                 (vcntNext >= Y_LO) & (vcntNext < Y_HI);
    xNext      = 10'(hcntNext - X_LO);
    yNext      = 9'(vcntNext - Y_LO);
  end

  // Lock tracking: a frame only counts toward lock if it closed with no error.
  always_comb begin
    stateNext    = state;
    goodCntNext  = goodCnt;
    frameBadNext = frameBad;
    if (vRise) begin
      frameBadNext = 1'b0;
    end else if (hErrNow) begin
      frameBadNext = 1'b1;
    end
    case (state)
      UNLOCKED: begin
        if (vRise) begin
          stateNext   = ACQUIRE;
          goodCntNext = '0;
        end
      end
      ACQUIRE: begin
        if (hErrNow | vErrNow) begin
          goodCntNext = '0;
        end else if (vRise & ~frameBad) begin
          goodCntNext = goodCnt + GW'(1);
          if (goodCnt + GW'(1) == GOOD_TARGET) begin
            stateNext = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (hErrNow | vErrNow) begin
          stateNext   = ACQUIRE;
          goodCntNext = '0;
        end
      end
      default: begin
        stateNext   = UNLOCKED;
        goodCntNext = '0;
      end
    endcase
  end

  // Stage 1: data sample (no reset on the pixel path)
  always_ff @(posedge clk) begin
    pix_p1 <= pixelIn;
  end

  // Stage 1/2: sync history and timing state. Sync history resets to the
  // idle (high) level so a reset in the middle of a line does not fake an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hs_p1    <= 1'b1;
      vs_p1    <= 1'b1;
      hs_p2    <= 1'b1;
      vs_p2    <= 1'b1;
      hcnt     <= '0;
      vcnt     <= '0;
      hSeen    <= 1'b0;
      vSeen    <= 1'b0;
      wdTrip   <= 1'b0;
      state    <= UNLOCKED;
      goodCnt  <= '0;
      frameBad <= 1'b0;
    end else begin
      hs_p1    <= Hsync_n;
      vs_p1    <= Vsync_n;
      hs_p2    <= hs_p1;
      vs_p2    <= vs_p1;
      hcnt     <= hcntNext;
      vcnt     <= vcntNext;
      hSeen    <= hSeen | hRise;
      vSeen    <= vSeen | vRise;
      wdTrip   <= hRise ? 1'b0 : (wdTrip | wdFire);
      state    <= stateNext;
      goodCnt  <= goodCntNext;
      frameBad <= frameBadNext;
    end
  end

  // Stage 2: registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p2        <= 1'b0;
      pix_p2        <= '0;
      posX_p2       <= '0;
      posY_p2       <= '0;
      lineStart_p2  <= 1'b0;
      frameStart_p2 <= 1'b0;
      locked        <= 1'b0;
      h_err         <= 1'b0;
      v_err         <= 1'b0;
      line_len      <= '0;
      frame_lines   <= '0;
    end else begin
      vld_p2        <= activeNow;
      pix_p2        <= activeNow ? pix_p1 : 12'd0;
      posX_p2       <= activeNow ? xNext : 10'd0;
      posY_p2       <= activeNow ? yNext : 9'd0;
      lineStart_p2  <= activeNow & (xNext == 10'd0);
      frameStart_p2 <= activeNow & (xNext == 10'd0) & (yNext == 9'd0);
      locked        <= (stateNext == LOCKED);
      h_err         <= hErrNow;
      v_err         <= vErrNow;
      if (hRise & hSeen) begin
        line_len <= linePeriod;
      end
      if (vRise & vSeen) begin
        frame_lines <= vcnt;
      end
    end
  end

  assign pixel_valid = vld_p2;
  assign pixelOut    = pix_p2;
  assign posX        = posX_p2;
  assign posY        = posY_p2;
  assign line_start  = lineStart_p2;
  assign frame_start = frameStart_p2;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Testbench for vga_sync_decoder, run on a scaled-down timing geometry:
// 40-clock lines (sync low at clocks 24..31, rise at 32, back porch 8),
// 30-line frames (Vsync low on lines 23..24, rise at line 25, back porch 5),
// 16x20 active area. Line/frame lengths are varied by moving the sync pulses.
module tb_vga_sync_decoder;

  localparam int SX = 16;
  localparam int SY = 20;
  localparam int HB = 8;
  localparam int VB = 5;
  localparam int HT = 40;
  localparam int VT = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Hsync_n = 1'b1;
  logic        Vsync_n = 1'b1;
  logic [11:0] pixelIn = '0;
  logic [11:0] pixelOut;
  logic        pixel_valid;
  logic [9:0]  posX;
  logic [8:0]  posY;
  logic        line_start, frame_start, locked, h_err, v_err;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;

  int nChecks = 0;
  int nErrors = 0;
  int curFrame = -1, curLine = 0, curClk = 0;
  int prvFrame = -1, prvLine = -1, prvClk = -1;
  int validCnt = 0, hErrCnt = 0, vErrCnt = 0, wdWinErr = 0;
  logic gotFirst = 1'b0;
  int firstX = -1, firstY = -1, firstFrame = -1;

  always #20 clk = ~clk;

  vga_sync_decoder #(
    .SCREEN_X(SX), .SCREEN_Y(SY), .H_BACK(HB), .V_BACK(VB),
    .H_MIN(38), .H_MAX(42), .V_MIN(28), .V_MAX(32), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .Hsync_n(Hsync_n), .Vsync_n(Vsync_n),
    .pixelIn(pixelIn), .pixelOut(pixelOut), .pixel_valid(pixel_valid),
    .posX(posX), .posY(posY), .line_start(line_start),
    .frame_start(frame_start), .locked(locked), .h_err(h_err),
    .v_err(v_err), .line_len(line_len), .frame_lines(frame_lines)
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic at(input int f, input int l, input int c);
    return (prvFrame == f) && (prvLine == l) && (prvClk == c);
  endfunction

  // Point checks keyed on the input sample that the current outputs belong to.
  task automatic probe();
    if (at(1, 0, 0)) begin
      checkEq("f1_x0y0_valid", 32'(pixel_valid), 1);
      checkEq("f1_x0y0_frame_start", 32'(frame_start), 1);
      checkEq("f1_x0y0_line_start", 32'(line_start), 1);
      checkEq("f1_x0y0_posX", 32'(posX), 0);
      checkEq("f1_x0y0_posY", 32'(posY), 0);
      checkEq("f1_x0y0_pixel", 32'(pixelOut), 0);
    end
    if (at(1, 10, 5)) begin
      checkEq("f1_x5y10_valid", 32'(pixel_valid), 1);
      checkEq("f1_x5y10_posX", 32'(posX), 5);
      checkEq("f1_x5y10_posY", 32'(posY), 10);
      checkEq("f1_x5y10_pixel", 32'(pixelOut), 32'h285);
      checkEq("f1_x5y10_line_start", 32'(line_start), 0);
    end
    if (at(1, 3, 0)) begin
      checkEq("f1_y3_line_start", 32'(line_start), 1);
      checkEq("f1_y3_frame_start", 32'(frame_start), 0);
    end
    if (at(1, 19, 15)) begin
      checkEq("f1_last_valid", 32'(pixel_valid), 1);
      checkEq("f1_last_posX", 32'(posX), 15);
      checkEq("f1_last_posY", 32'(posY), 19);
    end
    if (at(1, 0, 16)) begin
      checkEq("f1_xend_valid", 32'(pixel_valid), 0);
      checkEq("f1_xend_posX", 32'(posX), 0);
    end
    if (at(1, 20, 0)) begin
      checkEq("f1_yend_valid", 32'(pixel_valid), 0);
      checkEq("f1_yend_pixel", 32'(pixelOut), 0);
    end
    if (at(2, 24, 39)) checkEq("f2_locked_before_vrise", 32'(locked), 0);
    if (at(2, 25, 0))  checkEq("f2_locked_after_vrise", 32'(locked), 1);
    if (at(3, 10, 35)) checkEq("f3_watchdog_herr", 32'(h_err), 1);
    if (at(3, 10, 37)) begin
      checkEq("f3_stretch_herr", 32'(h_err), 1);
      checkEq("f3_stretch_line_len", 32'(line_len), 45);
      checkEq("f3_stretch_locked", 32'(locked), 0);
    end
    if (at(6, 5, 34)) begin
      checkEq("f6_len42_line_len", 32'(line_len), 42);
      checkEq("f6_len42_herr", 32'(h_err), 0);
    end
    if (at(6, 7, 30)) begin
      checkEq("f6_len38_line_len", 32'(line_len), 38);
      checkEq("f6_len38_herr", 32'(h_err), 0);
    end
    if (at(7, 19, 39)) checkEq("f7_locked_before", 32'(locked), 1);
    if (at(7, 20, 0)) begin
      checkEq("f7_short_verr", 32'(v_err), 1);
      checkEq("f7_short_frame_lines", 32'(frame_lines), 25);
      checkEq("f7_short_locked", 32'(locked), 0);
    end
    if (at(8, 10, 35)) checkEq("f8_watchdog_herr", 32'(h_err), 1);
    if (at(8, 10, 52)) checkEq("f8_long_line_len", 32'(line_len), 60);
    if (at(10, 0, 0)) begin
      checkEq("f10_frame_start", 32'(frame_start), 1);
      checkEq("f10_posY", 32'(posY), 0);
    end
  endtask

  task automatic resetChecks();
    checkEq("rst_valid", 32'(pixel_valid), 0);
    checkEq("rst_pixel", 32'(pixelOut), 0);
    checkEq("rst_posX", 32'(posX), 0);
    checkEq("rst_posY", 32'(posY), 0);
    checkEq("rst_line_start", 32'(line_start), 0);
    checkEq("rst_frame_start", 32'(frame_start), 0);
    checkEq("rst_locked", 32'(locked), 0);
    checkEq("rst_h_err", 32'(h_err), 0);
    checkEq("rst_v_err", 32'(v_err), 0);
    checkEq("rst_line_len", 32'(line_len), 0);
    checkEq("rst_frame_lines", 32'(frame_lines), 0);
  endtask

  task automatic tick(input logic h, input logic v, input logic r);
    Hsync_n = h;
    Vsync_n = v;
    rst     = r;
    pixelIn = {6'(curLine), 6'(curClk)};
    @(posedge clk);
    #1;
    if (pixel_valid === 1'b1) begin
      validCnt++;
      if (!gotFirst) begin
        gotFirst   = 1'b1;
        firstX     = int'(posX);
        firstY     = int'(posY);
        firstFrame = prvFrame;
      end
    end
    if (h_err === 1'b1) begin
      hErrCnt++;
      if (prvFrame == 8 && prvLine == 10 && prvClk < 52) wdWinErr++;
    end
    if (v_err === 1'b1) vErrCnt++;
    if (!r) begin
      resetChecks();
      validCnt = 0;
      gotFirst = 1'b0;
    end
    probe();
    prvFrame = curFrame;
    prvLine  = curLine;
    prvClk   = curClk;
  endtask

  // One frame of frameLen lines; up to two lines get a non-nominal length,
  // and a one-clock reset can be dropped at (rstLine, rstClk).
  task automatic runFrame(input int frame, input int frameLen,
                          input int sl1, input int len1,
                          input int sl2, input int len2,
                          input int rstLine, input int rstClk);
    int len;
    curFrame = frame;
    validCnt = 0;
    hErrCnt  = 0;
    vErrCnt  = 0;
    for (int l = 0; l < frameLen; l++) begin
      len = (l == sl1) ? len1 : ((l == sl2) ? len2 : HT);
      for (int c = 0; c < len; c++) begin
        curLine = l;
        curClk  = c;
        tick(!(c >= len - 16 && c < len - 8),
             !(l >= frameLen - 7 && l < frameLen - 5),
             !(l == rstLine && c == rstClk));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);

    runFrame(0, VT, -1, 0, -1, 0, -1, -1);
    checkEq("f0_valid_count", 32'(validCnt), 0);
    checkEq("f0_locked", 32'(locked), 0);

    runFrame(1, VT, -1, 0, -1, 0, -1, -1);
    checkEq("f1_valid_count", 32'(validCnt), SX * SY);
    checkEq("f1_line_len", 32'(line_len), HT);
    checkEq("f1_frame_lines", 32'(frame_lines), VT);
    checkEq("f1_locked", 32'(locked), 0);
    checkEq("f1_herr_count", 32'(hErrCnt), 0);

    runFrame(2, VT, -1, 0, -1, 0, -1, -1);
    checkEq("f2_locked", 32'(locked), 1);
    checkEq("f2_verr_count", 32'(vErrCnt), 0);

    runFrame(3, VT, 10, 45, -1, 0, -1, -1);
    checkEq("f3_herr_count", 32'(hErrCnt), 2);
    checkEq("f3_locked", 32'(locked), 0);

    runFrame(4, VT, -1, 0, -1, 0, -1, -1);
    checkEq("f4_locked", 32'(locked), 0);
    checkEq("f4_herr_count", 32'(hErrCnt), 0);

    runFrame(5, VT, -1, 0, -1, 0, -1, -1);
    checkEq("f5_relocked", 32'(locked), 1);

    runFrame(6, VT, 5, 42, 7, 38, -1, -1);
    checkEq("f6_herr_count", 32'(hErrCnt), 0);
    checkEq("f6_locked", 32'(locked), 1);

    runFrame(7, 25, -1, 0, -1, 0, -1, -1);
    checkEq("f7_verr_count", 32'(vErrCnt), 1);
    checkEq("f7_locked", 32'(locked), 0);

    runFrame(8, VT, 10, 60, -1, 0, -1, -1);
    checkEq("f8_watchdog_single", 32'(wdWinErr), 1);
    checkEq("f8_herr_count", 32'(hErrCnt), 2);
    checkEq("f8_frame_lines", 32'(frame_lines), VT);

    runFrame(9, VT, -1, 0, -1, 0, 12, 10);
    checkEq("f9_valid_after_reset", 32'(validCnt), 0);

    runFrame(10, VT, -1, 0, -1, 0, -1, -1);
    checkEq("f10_valid_count", 32'(validCnt), SX * SY);
    checkEq("f10_first_frame", 32'(firstFrame), 10);
    checkEq("f10_first_x", 32'(firstX), 0);
    checkEq("f10_first_y", 32'(firstY), 0);
    checkEq("f10_locked", 32'(locked), 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
